// File: rtl/circular_queue_ptr_pair_if.sv
// Request/status bundle for the circular queue pointer pair.
// The queue owner drives the advance requests; the pointer pair reports
// pointers, occupancy and the per-cycle accept/reject verdicts.
interface circular_queue_ptr_pair_if #(
  parameter int ENTRIES = 12,
  parameter int MAX_INC = 4
);
  localparam int PTR_WIDTH = $clog2(ENTRIES);
  localparam int CNT_WIDTH = $clog2(ENTRIES + 1);
  localparam int INC_WIDTH = $clog2(MAX_INC + 1);

  logic                 flush_i;
  logic [INC_WIDTH-1:0] enq_num_i;
  logic [INC_WIDTH-1:0] deq_num_i;
  logic                 enq_flag_o;
  logic [PTR_WIDTH-1:0] enq_value_o;
  logic                 deq_flag_o;
  logic [PTR_WIDTH-1:0] deq_value_o;
  logic [CNT_WIDTH-1:0] count_o;
  logic [CNT_WIDTH-1:0] free_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 enq_acc_o;
  logic                 deq_acc_o;
  logic                 err_ovf_o;
  logic                 err_unf_o;

  modport master (
    output flush_i, enq_num_i, deq_num_i,
    input  enq_flag_o, enq_value_o, deq_flag_o, deq_value_o,
    input  count_o, free_o, full_o, empty_o,
    input  enq_acc_o, deq_acc_o, err_ovf_o, err_unf_o
  );

  modport slave (
    input  flush_i, enq_num_i, deq_num_i,
    output enq_flag_o, enq_value_o, deq_flag_o, deq_value_o,
    output count_o, free_o, full_o, empty_o,
    output enq_acc_o, deq_acc_o, err_ovf_o, err_unf_o
  );
endinterface

// File: rtl/circular_queue_ptr_pair.sv
// Enqueue/dequeue pointer pair for a circular queue of arbitrary depth.
// Pointers are {flag, value}; the flag toggles on every wrap so that equal
// values with differing flags mean "full" and equal flags mean "empty".
// Each pointer advances all-or-nothing by up to MAX_INC entries per cycle.

// Invariant and parameter checks for the pointer pair.
module circular_queue_ptr_pair_chk #(
  parameter int ENTRIES = 12,
  parameter int MAX_INC = 4
) (
  input logic                                   clk_i,
  input logic                                   rst_ni,
  input logic [$clog2(ENTRIES + 1):0]           count_wide,
  input logic                                   full,
  input logic                                   empty,
  input logic [$clog2(ENTRIES)-1:0]             enq_value,
  input logic [$clog2(ENTRIES)-1:0]             deq_value,
  input logic [$clog2(MAX_INC + 1)-1:0]         enq_num,
  input logic [$clog2(MAX_INC + 1)-1:0]         deq_num
);
  localparam int PTR_WIDTH = $clog2(ENTRIES);
  localparam int CNT_WIDTH = $clog2(ENTRIES + 1);
  localparam int INC_WIDTH = $clog2(MAX_INC + 1);

  if (ENTRIES < 2 || MAX_INC < 1 || MAX_INC > ENTRIES) begin : g_bad_params
    $error("circular_queue_ptr_pair: need ENTRIES >= 2 and 1 <= MAX_INC <= ENTRIES");
  end

  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_wide <= (CNT_WIDTH + 1)'(ENTRIES));
  a_full_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(full && empty));
  a_enq_value: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (PTR_WIDTH + 1)'(enq_value) < (PTR_WIDTH + 1)'(ENTRIES));
  a_deq_value: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (PTR_WIDTH + 1)'(deq_value) < (PTR_WIDTH + 1)'(ENTRIES));
  a_enq_num_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    enq_num <= INC_WIDTH'(MAX_INC));
  a_deq_num_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    deq_num <= INC_WIDTH'(MAX_INC));
endmodule

module circular_queue_ptr_pair #(
  parameter int ENTRIES = 12,
  parameter int MAX_INC = 4
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  circular_queue_ptr_pair_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(ENTRIES);
  localparam int CNT_WIDTH = $clog2(ENTRIES + 1);
  localparam int INC_WIDTH = $clog2(MAX_INC + 1);
  localparam int CMP_WIDTH = CNT_WIDTH + INC_WIDTH;
  localparam logic [PTR_WIDTH:0] ENTRIES_P = (PTR_WIDTH + 1)'(ENTRIES);
  localparam logic [CNT_WIDTH:0] ENTRIES_C = (CNT_WIDTH + 1)'(ENTRIES);

  logic                 enq_flag_r, deq_flag_r;
  logic [PTR_WIDTH-1:0] enq_value_r, deq_value_r;
  logic                 enq_flag_s, deq_flag_s;
  logic [PTR_WIDTH-1:0] enq_value_s, deq_value_s;
  logic [CNT_WIDTH:0]   count_wide_s;
  logic [CNT_WIDTH-1:0] count_s, free_s;
  logic                 live_s;
  logic                 enq_acc_s, deq_acc_s, err_ovf_s, err_unf_s;

  // Advance a {flag, value} pointer by num with at most one wrap.
  function automatic logic [PTR_WIDTH:0] advance(
    input logic                 flag,
    input logic [PTR_WIDTH-1:0] value,
    input logic [INC_WIDTH-1:0] num
  );
    logic [PTR_WIDTH:0] sum;
    logic [PTR_WIDTH:0] res;
    sum = {1'b0, value} + (PTR_WIDTH + 1)'(num);
    if (sum >= ENTRIES_P) begin
      res = {~flag, PTR_WIDTH'(sum - ENTRIES_P)};
    end else begin
      res = {flag, sum[PTR_WIDTH-1:0]};
    end
    return res;
  endfunction

  // Occupancy from the registered pointers; differing flags mean enq has lapped.
  always_comb begin
    count_wide_s = {(CNT_WIDTH + 1){1'b0}};
    if (enq_flag_r == deq_flag_r) begin
      count_wide_s = (CNT_WIDTH + 1)'(enq_value_r) - (CNT_WIDTH + 1)'(deq_value_r);
    end else begin
      count_wide_s = ENTRIES_C + (CNT_WIDTH + 1)'(enq_value_r)
                   - (CNT_WIDTH + 1)'(deq_value_r);
    end
    count_s = count_wide_s[CNT_WIDTH-1:0];
    free_s  = CNT_WIDTH'(ENTRIES) - count_s;
  end

  // All-or-nothing acceptance against registered state; flush and reset silence verdicts.
  always_comb begin
    live_s    = rst_ni & ~bus.flush_i;
    enq_acc_s = 1'b0;
    err_ovf_s = 1'b0;
    deq_acc_s = 1'b0;
    err_unf_s = 1'b0;
    if (live_s && (bus.enq_num_i != {INC_WIDTH{1'b0}})) begin
      if (CMP_WIDTH'(bus.enq_num_i) <= CMP_WIDTH'(free_s)) begin
        enq_acc_s = 1'b1;
      end else begin
        err_ovf_s = 1'b1;
      end
    end else begin
      enq_acc_s = 1'b0;
    end
    if (live_s && (bus.deq_num_i != {INC_WIDTH{1'b0}})) begin
      if (CMP_WIDTH'(bus.deq_num_i) <= CMP_WIDTH'(count_s)) begin
        deq_acc_s = 1'b1;
      end else begin
        err_unf_s = 1'b1;
      end
    end else begin
      deq_acc_s = 1'b0;
    end
  end

  // Next pointer values: flush clears both, otherwise each advances only if accepted.
  always_comb begin
    {enq_flag_s, enq_value_s} = {enq_flag_r, enq_value_r};
    {deq_flag_s, deq_value_s} = {deq_flag_r, deq_value_r};
    if (bus.flush_i) begin
      {enq_flag_s, enq_value_s} = {(PTR_WIDTH + 1){1'b0}};
      {deq_flag_s, deq_value_s} = {(PTR_WIDTH + 1){1'b0}};
    end else begin
      if (enq_acc_s) begin
        {enq_flag_s, enq_value_s} = advance(enq_flag_r, enq_value_r, bus.enq_num_i);
      end else begin
        {enq_flag_s, enq_value_s} = {enq_flag_r, enq_value_r};
      end
      if (deq_acc_s) begin
        {deq_flag_s, deq_value_s} = advance(deq_flag_r, deq_value_r, bus.deq_num_i);
      end else begin
        {deq_flag_s, deq_value_s} = {deq_flag_r, deq_value_r};
      end
    end
  end

  // Pointer registers; the only state in the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enq_flag_r  <= 1'b0;
      enq_value_r <= {PTR_WIDTH{1'b0}};
      deq_flag_r  <= 1'b0;
      deq_value_r <= {PTR_WIDTH{1'b0}};
    end else begin
      enq_flag_r  <= enq_flag_s;
      enq_value_r <= enq_value_s;
      deq_flag_r  <= deq_flag_s;
      deq_value_r <= deq_value_s;
    end
  end

  assign bus.enq_flag_o  = enq_flag_r;
  assign bus.enq_value_o = enq_value_r;
  assign bus.deq_flag_o  = deq_flag_r;
  assign bus.deq_value_o = deq_value_r;
  assign bus.count_o     = count_s;
  assign bus.free_o      = free_s;
  assign bus.full_o      = (count_s == CNT_WIDTH'(ENTRIES));
  assign bus.empty_o     = (count_s == {CNT_WIDTH{1'b0}});
  assign bus.enq_acc_o   = enq_acc_s;
  assign bus.deq_acc_o   = deq_acc_s;
  assign bus.err_ovf_o   = err_ovf_s;
  assign bus.err_unf_o   = err_unf_s;

  circular_queue_ptr_pair_chk #(
    .ENTRIES (ENTRIES),
    .MAX_INC (MAX_INC)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .count_wide (count_wide_s),
    .full       (bus.full_o),
    .empty      (bus.empty_o),
    .enq_value  (enq_value_r),
    .deq_value  (deq_value_r),
    .enq_num    (bus.enq_num_i),
    .deq_num    (bus.deq_num_i)
  );
endmodule

// File: tb/tb_circular_queue_ptr_pair.sv
// Bench for circular_queue_ptr_pair: a 12-entry and a 16-entry instance share
// the same request stream. A count/absolute-position model predicts every
// output each cycle; literal checks on the 12-entry instance pin the model.
module tb_circular_queue_ptr_pair;
  localparam int E0 = 12;
  localparam int E1 = 16;
  localparam int MI = 4;
  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] enq_num = 3'd0;
  logic [2:0] deq_num = 3'd0;
  bit         chk_on = 1'b1;

  int checks = 0;
  int errors = 0;

  // Model: occupancy plus absolute positions modulo 2*ENTRIES.
  int m_cnt [NI] = '{0, 0};
  int m_enq [NI] = '{0, 0};
  int m_deq [NI] = '{0, 0};

  always #5 clk = ~clk;

  circular_queue_ptr_pair_if #(.ENTRIES(E0), .MAX_INC(MI)) bus0 ();
  circular_queue_ptr_pair_if #(.ENTRIES(E1), .MAX_INC(MI)) bus1 ();

  assign bus0.flush_i   = flush;
  assign bus0.enq_num_i = enq_num;
  assign bus0.deq_num_i = deq_num;
  assign bus1.flush_i   = flush;
  assign bus1.enq_num_i = enq_num;
  assign bus1.deq_num_i = deq_num;

  circular_queue_ptr_pair #(.ENTRIES(E0), .MAX_INC(MI)) dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus0)
  );
  circular_queue_ptr_pair #(.ENTRIES(E1), .MAX_INC(MI)) dut1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus1)
  );

  function automatic int ent_of(input int i);
    return (i == 0) ? E0 : E1;
  endfunction

  function automatic bit enq_ok(input int i);
    return (enq_num != 3'd0) && (int'(enq_num) <= ent_of(i) - m_cnt[i]);
  endfunction

  function automatic bit deq_ok(input int i);
    return (deq_num != 3'd0) && (int'(deq_num) <= m_cnt[i]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input int ef, input int ev, input int df,
                          input int dv, input int cnt, input int fr, input int fu,
                          input int em, input int ea, input int da, input int eo,
                          input int eu);
    int  e;
    bit  live;
    e    = ent_of(i);
    live = rst_n && !flush;
    chk($sformatf("i%0d.enq_flag", i),  ef,  m_enq[i] / e);
    chk($sformatf("i%0d.enq_value", i), ev,  m_enq[i] % e);
    chk($sformatf("i%0d.deq_flag", i),  df,  m_deq[i] / e);
    chk($sformatf("i%0d.deq_value", i), dv,  m_deq[i] % e);
    chk($sformatf("i%0d.count", i),     cnt, m_cnt[i]);
    chk($sformatf("i%0d.free", i),      fr,  e - m_cnt[i]);
    chk($sformatf("i%0d.full", i),      fu,  int'(m_cnt[i] == e));
    chk($sformatf("i%0d.empty", i),     em,  int'(m_cnt[i] == 0));
    chk($sformatf("i%0d.enq_acc", i),   ea,  int'(live && enq_ok(i)));
    chk($sformatf("i%0d.deq_acc", i),   da,  int'(live && deq_ok(i)));
    chk($sformatf("i%0d.err_ovf", i),   eo,  int'(live && (enq_num != 3'd0) && !enq_ok(i)));
    chk($sformatf("i%0d.err_unf", i),   eu,  int'(live && (deq_num != 3'd0) && !deq_ok(i)));
  endtask

  // Model update on each edge: accepted moves advance positions and occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i] <= 0;
        m_enq[i] <= 0;
        m_deq[i] <= 0;
      end
    end else if (flush) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i] <= 0;
        m_enq[i] <= 0;
        m_deq[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i] <= m_cnt[i] + (enq_ok(i) ? int'(enq_num) : 0)
                             - (deq_ok(i) ? int'(deq_num) : 0);
        m_enq[i] <= enq_ok(i) ? (m_enq[i] + int'(enq_num)) % (2 * ent_of(i)) : m_enq[i];
        m_deq[i] <= deq_ok(i) ? (m_deq[i] + int'(deq_num)) % (2 * ent_of(i)) : m_deq[i];
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst(0, int'(bus0.enq_flag_o), int'(bus0.enq_value_o), int'(bus0.deq_flag_o),
               int'(bus0.deq_value_o), int'(bus0.count_o), int'(bus0.free_o),
               int'(bus0.full_o), int'(bus0.empty_o), int'(bus0.enq_acc_o),
               int'(bus0.deq_acc_o), int'(bus0.err_ovf_o), int'(bus0.err_unf_o));
      cmp_inst(1, int'(bus1.enq_flag_o), int'(bus1.enq_value_o), int'(bus1.deq_flag_o),
               int'(bus1.deq_value_o), int'(bus1.count_o), int'(bus1.free_o),
               int'(bus1.full_o), int'(bus1.empty_o), int'(bus1.enq_acc_o),
               int'(bus1.deq_acc_o), int'(bus1.err_ovf_o), int'(bus1.err_unf_o));
    end
  end

  // Apply a request and wait until the comb verdicts are observable.
  task automatic drive(input int e, input int d, input bit f);
    enq_num = 3'(e);
    deq_num = 3'(d);
    flush   = f;
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int e, input int d, input bit f);
    drive(e, d, f);
    finish_cycle();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(bus0.count_o), 0);
    chk("rst_free",  int'(bus0.free_o), 12);
    chk("rst_empty", int'(bus0.empty_o), 1);
    chk("rst_full",  int'(bus0.full_o), 0);
    rst_n = 1'b1;

    // Fill with three 4-wide enqueues, then drain
    repeat (3) step(4, 0, 1'b0);
    chk("fill_count",     int'(bus0.count_o), 12);
    chk("fill_full",      int'(bus0.full_o), 1);
    chk("fill_enq_flag",  int'(bus0.enq_flag_o), 1);
    chk("fill_enq_value", int'(bus0.enq_value_o), 0);
    repeat (3) step(0, 4, 1'b0);
    chk("drain_deq_flag",  int'(bus0.deq_flag_o), 1);
    chk("drain_deq_value", int'(bus0.deq_value_o), 0);
    chk("drain_empty",     int'(bus0.empty_o), 1);

    // Overflow at count 10
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(2, 0, 1'b0);
    chk("ovf_pre_count", int'(bus0.count_o), 10);
    drive(3, 0, 1'b0);
    chk("ovf_err", int'(bus0.err_ovf_o), 1);
    chk("ovf_acc", int'(bus0.enq_acc_o), 0);
    finish_cycle();
    chk("ovf_hold_count", int'(bus0.count_o), 10);
    step(2, 0, 1'b0);
    chk("ovf_fill_count", int'(bus0.count_o), 12);

    // Full with enq 1 and deq 1: dequeue does not make room
    drive(1, 1, 1'b0);
    chk("fulleq_deq_acc", int'(bus0.deq_acc_o), 1);
    chk("fulleq_enq_acc", int'(bus0.enq_acc_o), 0);
    chk("fulleq_err_ovf", int'(bus0.err_ovf_o), 1);
    finish_cycle();
    chk("fulleq_count", int'(bus0.count_o), 11);

    // Underflow at count 2
    step(0, 4, 1'b0);
    step(0, 4, 1'b0);
    step(0, 1, 1'b0);
    chk("unf_pre_count", int'(bus0.count_o), 2);
    drive(0, 3, 1'b0);
    chk("unf_err", int'(bus0.err_unf_o), 1);
    chk("unf_acc", int'(bus0.deq_acc_o), 0);
    finish_cycle();
    chk("unf_hold_count", int'(bus0.count_o), 2);
    drive(1, 3, 1'b0);
    chk("unf_enq_acc", int'(bus0.enq_acc_o), 1);
    chk("unf_err2",    int'(bus0.err_unf_o), 1);
    finish_cycle();
    chk("unf_count3", int'(bus0.count_o), 3);

    // Flush overrides active requests
    step(4, 0, 1'b0);
    chk("flush_pre_count", int'(bus0.count_o), 7);
    drive(4, 2, 1'b1);
    chk("flush_enq_acc", int'(bus0.enq_acc_o), 0);
    chk("flush_deq_acc", int'(bus0.deq_acc_o), 0);
    chk("flush_err_ovf", int'(bus0.err_ovf_o), 0);
    chk("flush_err_unf", int'(bus0.err_unf_o), 0);
    finish_cycle();
    chk("flush_count",     int'(bus0.count_o), 0);
    chk("flush_enq_value", int'(bus0.enq_value_o), 0);
    chk("flush_enq_flag",  int'(bus0.enq_flag_o), 0);
    chk("flush_deq_value", int'(bus0.deq_value_o), 0);
    chk("flush_deq_flag",  int'(bus0.deq_flag_o), 0);

    // Enqueue of 3 from value 10 wraps to value 1
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(2, 0, 1'b0);
    chk("wrap_pre_value", int'(bus0.enq_value_o), 10);
    step(0, 4, 1'b0);
    step(3, 0, 1'b0);
    chk("wrap_value", int'(bus0.enq_value_o), 1);
    chk("wrap_flag",  int'(bus0.enq_flag_o), 1);
    chk("wrap_count", int'(bus0.count_o), 9);

    // Asynchronous reset in the middle of traffic
    drive(2, 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count",     int'(bus0.count_o), 0);
    chk("arst_empty",     int'(bus0.empty_o), 1);
    chk("arst_free",      int'(bus0.free_o), 12);
    chk("arst_enq_value", int'(bus0.enq_value_o), 0);
    chk("arst_enq_acc",   int'(bus0.enq_acc_o), 0);
    chk("arst_deq_acc",   int'(bus0.deq_acc_o), 0);
    finish_cycle();
    enq_num = 3'd0;
    deq_num = 3'd0;
    rst_n   = 1'b1;

    // Random traffic, alternating enqueue-heavy and dequeue-heavy phases
    for (int k = 0; k < 4000; k++) begin
      if ((k / 200) % 2 == 0) begin
        step(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
             ($urandom_range(0, 99) == 0));
      end else begin
        step(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
             ($urandom_range(0, 99) == 0));
      end
    end

    enq_num = 3'd0;
    deq_num = 3'd0;
    flush   = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
